// File: rtl/fu_mul_sequencer.sv
// ---------------------------------------------------------------------------
// fu_mul_sequencer
//
// Multi-cycle 32x32 unsigned multiplier (low 32 bits of the product) built on
// top of the shared ALU/shifter function unit. No multiplier array exists
// here. For each set bit i of the multiplier, the block runs two steps on the
// function unit:
//   SHIFT: shreg = mcand << i   (shifter, FS_SHL)
//   ADD  : acc   = acc + shreg  (ALU, FS_ADD)
// The top level routes the function-unit inputs to this block while fu_own=1.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1. The producer holds its data stable while
// valid=1 and ready=0. req_ready is high only in IDLE. resp_valid is high
// only in DONE, and resp_product/resp_ovf stay constant until resp_ready.
//
// Latency: if the request is accepted in cycle 0 and p = popcount(req_b),
// resp_valid first goes high in cycle 3p+2.
//
// Optional build macro: FU_MUL_OVF_EN
//   defined   -> resp_ovf=1 iff the full 64-bit product exceeds 2^32-1
//   undefined -> no overflow logic; resp_ovf tied to 0
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   req_valid/req_ready      request handshake
//   req_a, req_b             multiplicand, multiplier
//   resp_valid/resp_ready    response handshake
//   resp_product, resp_ovf   low 32 bits of product, overflow flag
//   fu_own                   block drives the function unit this cycle
//   fu_a, fu_b, fu_fs, fu_sh function-unit operand/select outputs
//   fu_out, fu_c             function-unit result and carry flag
// ---------------------------------------------------------------------------
module fu_mul_sequencer #(
  parameter logic [4:0] FS_ADD = 5'b00010,
  parameter logic [4:0] FS_SHL = 5'b11000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_product,
  output logic        resp_ovf,
  output logic        fu_own,
  output logic [31:0] fu_a,
  output logic [31:0] fu_b,
  output logic [4:0]  fu_fs,
  output logic [4:0]  fu_sh,
  input  logic [31:0] fu_out,
  input  logic        fu_c
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    SHIFT = 3'd2,
    ADD   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] acc;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] shreg;
  logic [4:0]  idx;
  logic [4:0]  low_idx;
  logic        accept;

  assign accept = (state == IDLE) && req_valid;

  // Index of the lowest set bit of mplier. Scanning from the top down lets
  // the last match (the lowest bit) win.
  always_comb begin
    low_idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (mplier[i]) low_idx = i[4:0];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and all combinational outputs
  always_comb begin
    state_nxt    = state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_product = 32'd0;
    fu_own       = 1'b0;
    fu_a         = 32'd0;
    fu_b         = 32'd0;
    fu_fs        = FS_ADD;
    fu_sh        = 5'd0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = SCAN;
      end
      SCAN: begin
        if (mplier == 32'd0) state_nxt = DONE;
        else                 state_nxt = SHIFT;
      end
      SHIFT: begin
        fu_own    = 1'b1;
        fu_fs     = FS_SHL;
        fu_b      = mcand;
        fu_sh     = idx;
        state_nxt = ADD;
      end
      ADD: begin
        fu_own    = 1'b1;
        fu_fs     = FS_ADD;
        fu_a      = acc;
        fu_b      = shreg;
        state_nxt = SCAN;
      end
      DONE: begin
        resp_valid   = 1'b1;
        resp_product = acc;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= 32'd0;
      mcand  <= 32'd0;
      mplier <= 32'd0;
      shreg  <= 32'd0;
      idx    <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mcand  <= req_a;
            mplier <= req_b;
            acc    <= 32'd0;
          end
        end
        SCAN: begin
          if (mplier != 32'd0) begin
            idx    <= low_idx;
            // x & (x-1) clears exactly the lowest set bit
            mplier <= mplier & (mplier - 32'd1);
          end
        end
        SHIFT:   shreg <= fu_out;
        ADD:     acc   <= fu_out;
        default: ;
      endcase
    end
  end

`ifdef FU_MUL_OVF_EN
  logic       ovf;
  logic [5:0] lost_sh;
  logic       shift_lost;

  // Bits of mcand pushed past bit 31 by a left shift of idx are the top idx
  // bits, i.e. mcand >> (32-idx). idx=0 loses nothing.
  assign lost_sh    = 6'd32 - {1'b0, idx};
  assign shift_lost = (idx != 5'd0) && ((mcand >> lost_sh) != 32'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (accept) ovf <= 1'b0;
        SHIFT:   if (shift_lost) ovf <= 1'b1;
        ADD:     if (fu_c) ovf <= 1'b1;
        default: ;
      endcase
    end
  end

  assign resp_ovf = (state == DONE) && ovf;
`else
  logic unused_fu_c;
  assign unused_fu_c = fu_c;
  assign resp_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_fu_mul_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for fu_mul_sequencer. Includes a small behavioural model of the
// shared function unit (shift-left / add with carry) so the sequencer can run
// end to end. Directed vectors with hand-computed products and latencies.
// ---------------------------------------------------------------------------
module tb_fu_mul_sequencer;

  localparam logic [4:0] FS_ADD = 5'b00010;
  localparam logic [4:0] FS_SHL = 5'b11000;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_product;
  logic        resp_ovf;
  logic        fu_own;
  logic [31:0] fu_a;
  logic [31:0] fu_b;
  logic [4:0]  fu_fs;
  logic [4:0]  fu_sh;
  logic [31:0] fu_out;
  logic        fu_c;
  logic [32:0] fu_sum;

  int          checks;
  int          errors;
  int          cyc;
  logic        own_seen;
  logic [4:0]  sh_q[$];
  logic [31:0] exp_q[$];

  // Expected overflow flags depend on the build option.
`ifdef FU_MUL_OVF_EN
  localparam logic OVF_FULL = 1'b1;
  localparam logic OVF_EDGE = 1'b1;
`else
  localparam logic OVF_FULL = 1'b0;
  localparam logic OVF_EDGE = 1'b0;
`endif

  fu_mul_sequencer #(
    .FS_ADD(FS_ADD),
    .FS_SHL(FS_SHL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_product (resp_product),
    .resp_ovf     (resp_ovf),
    .fu_own       (fu_own),
    .fu_a         (fu_a),
    .fu_b         (fu_b),
    .fu_fs        (fu_fs),
    .fu_sh        (fu_sh),
    .fu_out       (fu_out),
    .fu_c         (fu_c)
  );

  // Function unit model
  assign fu_sum = {1'b0, fu_a} + {1'b0, fu_b};
  assign fu_out = (fu_fs == FS_SHL) ? (fu_b << fu_sh) : fu_sum[31:0];
  assign fu_c   = (fu_fs == FS_SHL) ? 1'b0 : fu_sum[32];

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request from a negedge, wait for the response, check latency
  // and result, optionally hold off resp_ready for 'hold' cycles, then
  // complete and check the return to IDLE.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_p, input logic exp_o,
                         input int exp_cyc, input int hold);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    req_a      = a;
    req_b      = b;
    req_valid  = 1'b1;
    resp_ready = (hold == 0);
    sh_q.delete();
    own_seen   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // Operands are latched; scribbling on the request bus must not matter.
    req_valid = 1'b0;
    req_a     = 32'hDEAD_BEEF;
    req_b     = 32'hFFFF_FFFF;
    cyc       = 1;
    while (!resp_valid && cyc < 200) begin
      if (fu_own) own_seen = 1'b1;
      if (fu_own && fu_fs == FS_SHL) sh_q.push_back(fu_sh);
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, exp_cyc);
    check({tag, "_product"}, resp_product, exp_p);
    check({tag, "_ovf"}, {31'd0, resp_ovf}, {31'd0, exp_o});
    check({tag, "_own_done"}, {31'd0, fu_own}, 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold_valid"}, {31'd0, resp_valid}, 32'd1);
      check({tag, "_hold_product"}, resp_product, exp_p);
      check({tag, "_hold_req_ready"}, {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, "_post_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_post_req_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_a      = 32'd0;
    req_b      = 32'd0;
    resp_ready = 1'b0;
    own_seen   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_product", resp_product, 32'd0);
    check("rst_ovf", {31'd0, resp_ovf}, 32'd0);
    check("rst_fu_own", {31'd0, fu_own}, 32'd0);
    check("rst_fu_fs", {27'd0, fu_fs}, {27'd0, FS_ADD});
    rst_n = 1'b1;
    @(negedge clk);

    // Zero multiplier: p=0 -> cycle 2, function unit never used
    run_mul("zero", 32'h1234_5678, 32'd0, 32'd0, 1'b0, 2, 0);
    check("zero_own_never", {31'd0, own_seen}, 32'd0);

    // Small product: 7*5, shifts by 0 then 2
    run_mul("small", 32'd7, 32'd5, 32'd35, 1'b0, 8, 0);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd2);
    check("small_sh_count", sh_q.size(), 32'd2);
    while (exp_q.size() > 0 && sh_q.size() > 0)
      check("small_sh", {27'd0, sh_q.pop_front()}, exp_q.pop_front());

    // Full width: 0xFFFFFFFF^2 = 0xFFFFFFFE_00000001
    run_mul("full", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, OVF_FULL, 98, 0);

    // Overflow edges
    run_mul("edge_ovf", 32'h0001_0000, 32'h0001_0000, 32'd0, OVF_EDGE, 5, 0);
    run_mul("edge_max", 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 1'b0, 8, 0);

    // Backpressure: 3*4 (p=1 -> cycle 5), consumer stalls 5 cycles
    run_mul("bp", 32'd3, 32'd4, 32'd12, 1'b0, 5, 5);

    // Reset during ADD of 0xFFFF*0xFFFF
    req_a     = 32'h0000_FFFF;
    req_b     = 32'h0000_FFFF;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cyc       = 0;
    while (!(fu_own && fu_fs == FS_ADD) && cyc < 50) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check("mid_reached_add", {31'd0, fu_own}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_fu_own", {31'd0, fu_own}, 32'd0);
    check("mid_req_ready", {31'd0, req_ready}, 32'd1);
    check("mid_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("mid_product", resp_product, 32'd0);
    check("mid_ovf", {31'd0, resp_ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_mul("after_rst", 32'd6, 32'd7, 32'd42, 1'b0, 11, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
